sdram_burst_dma: RTL and testbench

IO-mapped DMA engine that copies blocks of 4-word bursts from one SDRAM region to another without CPU involvement. It sits on the 8-bit IO bus beside the serial, keyboard and timer modules. It masters one spare port of the SDRAM burst controller (req/wren/ready/offset protocol). A level interrupt output feeds a free input of the interrupt controller.

---
 rtl/sdram_burst_dma_pkg.sv | 45 ++++
 rtl/sdram_burst_dma_buffer.sv | 31 +++
 rtl/sdram_burst_dma.sv | 217 +++++++++++++++++++++
 tb/tb_sdram_burst_dma.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_burst_dma_pkg.sv
// ----------------------------------------------------------------------------
// sdram_burst_dma_pkg: state type and register map (SDRAM_BURST_DMA_FILL_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sdram_burst_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    NEXT = 2'd3
  } state_t;

  localparam logic [3:0] ADDR_SRC0 = 4'd0;
  localparam logic [3:0] ADDR_SRC1 = 4'd1;
  localparam logic [3:0] ADDR_SRC2 = 4'd2;
  localparam logic [3:0] ADDR_DST0 = 4'd3;
  localparam logic [3:0] ADDR_DST1 = 4'd4;
  localparam logic [3:0] ADDR_DST2 = 4'd5;
  localparam logic [3:0] ADDR_CNT0 = 4'd6;
  localparam logic [3:0] ADDR_CNT1 = 4'd7;
  localparam logic [3:0] ADDR_CTRL = 4'd8;

  localparam int CTL_START  = 0;
  localparam int CTL_ABORT  = 1;
  localparam int CTL_INT_EN = 2;
  localparam int CTL_CLEAR  = 3;

  localparam int STS_BUSY    = 0;
  localparam int STS_DONE    = 1;
  localparam int STS_INT_EN  = 2;
  localparam int STS_ABORTED = 3;

`ifdef SDRAM_BURST_DMA_FILL_EN
  localparam logic [3:0] ADDR_FILL_LO = 4'd9;
  localparam logic [3:0] ADDR_FILL_HI = 4'd10;
  localparam int CTL_FILL = 4;
  localparam int STS_FILL = 4;
`endif

endpackage

`default_nettype wire

// File: rtl/sdram_burst_dma_buffer.sv
// ----------------------------------------------------------------------------
// burst_buffer: 4x16 word store, offset-indexed write, combinational read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module burst_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [1:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] r_mem [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sdram_burst_dma.sv
// ----------------------------------------------------------------------------
// sdram_burst_dma: IO-mapped 4-word burst copy engine (option SDRAM_BURST_DMA_FILL_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sdram_burst_dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        wren,
  input  logic [3:0]  A,
  input  logic [7:0]  from_cpu,
  output logic [7:0]  to_cpu,
  output logic        dma_int,
  output logic        mem_req,
  output logic        mem_wren,
  output logic [23:0] mem_addr,
  output logic [15:0] to_mem,
  input  logic [15:0] from_mem,
  input  logic [1:0]  mem_offset,
  input  logic        mem_ready
);
  import sdram_burst_dma_pkg::*;

  state_t      r_state;
  logic [23:0] r_src;
  logic [23:0] r_dst;
  logic [15:0] r_count;
  logic        r_int_en;
  logic        r_done;
  logic        r_aborted;
  logic        r_abort_pending;

  logic        w_busy;
  logic        w_wr;
  logic        w_cfg_wr;
  logic        w_ctrl_wr;
  logic        w_fill;
  logic        w_start_fill;
  logic        w_last_word;
  logic [23:0] w_src_inc;
  logic [23:0] w_dst_inc;
  logic [15:0] w_buf_rd;
  logic [7:0]  w_status;
  logic [7:0]  w_rd_data;

  assign w_busy      = (r_state != IDLE);
  assign w_wr        = ce & wren;
  assign w_cfg_wr    = w_wr & ~w_busy;
  assign w_ctrl_wr   = w_wr && (A == ADDR_CTRL);
  assign w_last_word = mem_ready && (mem_offset == 2'd3);
  assign w_src_inc   = r_src + 24'd4;
  assign w_dst_inc   = r_dst + 24'd4;

`ifdef SDRAM_BURST_DMA_FILL_EN
  logic       r_fill_mode;
  logic [7:0] r_fill_lo;
  logic [7:0] r_fill_hi;
  assign w_fill       = r_fill_mode;
  assign w_start_fill = from_cpu[CTL_FILL];
  assign to_mem       = r_fill_mode ? {r_fill_hi, r_fill_lo} : w_buf_rd;
`else
  assign w_fill       = 1'b0;
  assign w_start_fill = 1'b0;
  assign to_mem       = w_buf_rd;
`endif

  burst_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    ((r_state == RD) && mem_ready),
    .waddr (mem_offset),
    .wdata (from_mem),
    .raddr (mem_offset),
    .rdata (w_buf_rd)
  );

  always_comb begin
    w_status              = 8'h00;
    w_status[STS_BUSY]    = w_busy;
    w_status[STS_DONE]    = r_done;
    w_status[STS_INT_EN]  = r_int_en;
    w_status[STS_ABORTED] = r_aborted;
`ifdef SDRAM_BURST_DMA_FILL_EN
    w_status[STS_FILL]    = r_fill_mode;
`endif
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (A)
      ADDR_SRC0:    w_rd_data = r_src[7:0];
      ADDR_SRC1:    w_rd_data = r_src[15:8];
      ADDR_SRC2:    w_rd_data = r_src[23:16];
      ADDR_DST0:    w_rd_data = r_dst[7:0];
      ADDR_DST1:    w_rd_data = r_dst[15:8];
      ADDR_DST2:    w_rd_data = r_dst[23:16];
      ADDR_CNT0:    w_rd_data = r_count[7:0];
      ADDR_CNT1:    w_rd_data = r_count[15:8];
      ADDR_CTRL:    w_rd_data = w_status;
`ifdef SDRAM_BURST_DMA_FILL_EN
      ADDR_FILL_LO: w_rd_data = r_fill_lo;
      ADDR_FILL_HI: w_rd_data = r_fill_hi;
`endif
      default:      w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_src           <= '0;
      r_dst           <= '0;
      r_count         <= '0;
      r_int_en        <= 1'b0;
      r_done          <= 1'b0;
      r_aborted       <= 1'b0;
      r_abort_pending <= 1'b0;
      to_cpu          <= '0;
      dma_int         <= 1'b0;
      mem_req         <= 1'b0;
      mem_wren        <= 1'b0;
      mem_addr        <= '0;
`ifdef SDRAM_BURST_DMA_FILL_EN
      r_fill_mode     <= 1'b0;
      r_fill_lo       <= '0;
      r_fill_hi       <= '0;
`endif
    end else begin
      if (ce) to_cpu <= w_rd_data;
      dma_int <= r_done & r_int_en;

      if (w_cfg_wr) begin
        case (A)
          ADDR_SRC0:    r_src[7:0]     <= from_cpu;
          ADDR_SRC1:    r_src[15:8]    <= from_cpu;
          ADDR_SRC2:    r_src[23:16]   <= from_cpu;
          ADDR_DST0:    r_dst[7:0]     <= from_cpu;
          ADDR_DST1:    r_dst[15:8]    <= from_cpu;
          ADDR_DST2:    r_dst[23:16]   <= from_cpu;
          ADDR_CNT0:    r_count[7:0]   <= from_cpu;
          ADDR_CNT1:    r_count[15:8]  <= from_cpu;
`ifdef SDRAM_BURST_DMA_FILL_EN
          ADDR_FILL_LO: r_fill_lo      <= from_cpu;
          ADDR_FILL_HI: r_fill_hi      <= from_cpu;
          ADDR_CTRL:    r_fill_mode    <= from_cpu[CTL_FILL];
`endif
          default: ;
        endcase
      end

      // Clear is applied before the FSM so a same-write start can set done again.
      if (w_ctrl_wr) begin
        r_int_en <= from_cpu[CTL_INT_EN];
        if (from_cpu[CTL_CLEAR]) begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
        end
        if (w_busy && from_cpu[CTL_ABORT]) r_abort_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_ctrl_wr && from_cpu[CTL_START]) begin
            if (r_count == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state  <= w_start_fill ? WR : RD;
              mem_req  <= 1'b1;
              mem_wren <= w_start_fill;
              mem_addr <= w_start_fill ? {r_dst[23:2], 2'b00} : {r_src[23:2], 2'b00};
            end
          end
        end
        RD: begin
          if (w_last_word) begin
            r_state  <= WR;
            mem_wren <= 1'b1;
            mem_addr <= {r_dst[23:2], 2'b00};
          end
        end
        WR: begin
          if (w_last_word) begin
            r_state  <= NEXT;
            mem_req  <= 1'b0;
            mem_wren <= 1'b0;
            mem_addr <= '0;
          end
        end
        NEXT: begin
          r_dst   <= w_dst_inc;
          r_src   <= w_fill ? r_src : w_src_inc;
          r_count <= r_count - 16'd1;
          if (r_count == 16'd1) begin
            r_done          <= 1'b1;
            r_abort_pending <= 1'b0;
            r_state         <= IDLE;
          end else if (r_abort_pending) begin
            r_aborted       <= 1'b1;
            r_abort_pending <= 1'b0;
            r_state         <= IDLE;
          end else begin
            r_state  <= w_fill ? WR : RD;
            mem_req  <= 1'b1;
            mem_wren <= w_fill;
            mem_addr <= w_fill ? {w_dst_inc[23:2], 2'b00} : {w_src_inc[23:2], 2'b00};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_burst_dma.sv
// ----------------------------------------------------------------------------
// tb_sdram_burst_dma: randomized bench with an SDRAM responder and burst model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sdram_burst_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        wren = 1'b0;
  logic [3:0]  A = 4'd0;
  logic [7:0]  from_cpu = 8'd0;
  logic [7:0]  to_cpu;
  logic        dma_int;
  logic        mem_req;
  logic        mem_wren;
  logic [23:0] mem_addr;
  logic [15:0] to_mem;
  logic [15:0] from_mem = 16'd0;
  logic [1:0]  mem_offset = 2'd0;
  logic        mem_ready = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [63:0] data;
  } burst_t;

  burst_t obs[$];
  burst_t exp_q[$];

  sdram_burst_dma dut (
    .clk(clk), .rst(rst), .ce(ce), .wren(wren), .A(A), .from_cpu(from_cpu),
    .to_cpu(to_cpu), .dma_int(dma_int), .mem_req(mem_req), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .to_mem(to_mem), .from_mem(from_mem),
    .mem_offset(mem_offset), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of word address: 0x100.. gives 0x1111..0x4444.
  function automatic logic [15:0] word(input logic [23:0] a);
    logic [15:0] base;
    base = a[17:2] - 16'h0040;
    return (16'h1111 * (16'(a[1:0]) + 16'd1)) ^ base;
  endfunction

  // Reference: n read/write pairs, addresses aligned, written data = words read.
  function automatic void model(input logic [23:0] s, input logic [23:0] d, input int n);
    burst_t e;
    logic [23:0] ra, wa;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      ra = (s + 24'(4 * i)) & 24'hFFFFFC;
      wa = (d + 24'(4 * i)) & 24'hFFFFFC;
      e.wr = 1'b0; e.addr = ra; e.data = '0;
      exp_q.push_back(e);
      e.wr = 1'b1; e.addr = wa;
      e.data = {word(ra + 24'd3), word(ra + 24'd2), word(ra + 24'd1), word(ra)};
      exp_q.push_back(e);
    end
  endfunction

  // SDRAM controller responder with random latency and inter-word gaps.
  initial begin
    burst_t b;
    bit kill;
    int lat;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) continue;
      b.wr = mem_wren; b.addr = mem_addr; b.data = '0;
      kill = 1'b0;
      lat = $urandom_range(0, 2);
      for (int k = 0; k < 4 && !kill; k++) begin
        for (int g = 0; g < lat && !kill; g++) begin
          @(negedge clk);
          if (rst) kill = 1'b1;
        end
        if (!kill) begin
          mem_offset = 2'(k);
          from_mem = word(b.addr + 24'(k));
          mem_ready = 1'b1;
          #1;
          if (b.wr) b.data[16*k +: 16] = to_mem;
          @(negedge clk);
          mem_ready = 1'b0;
          if (rst) kill = 1'b1;
        end
        lat = $urandom_range(0, 1);
      end
      if (!kill) begin
        obs.push_back(b);
        if (b.wr) begin
          total++;
          if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL req_drop_after_write got=%b want=0", mem_req);
          end
        end
      end
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; wren = 1'b1; A = a; from_cpu = d;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; wren = 1'b0; A = a;
    @(negedge clk);
    ce = 1'b0;
    d = to_cpu;
  endtask

  task automatic read24(input logic [3:0] base, output logic [23:0] v);
    logic [7:0] b0, b1, b2;
    cpu_read(base, b0);
    cpu_read(base + 4'd1, b1);
    cpu_read(base + 4'd2, b2);
    v = {b2, b1, b0};
  endtask

  task automatic set_regs(input logic [23:0] s, input logic [23:0] d, input logic [15:0] n);
    cpu_write(4'd0, s[7:0]);  cpu_write(4'd1, s[15:8]); cpu_write(4'd2, s[23:16]);
    cpu_write(4'd3, d[7:0]);  cpu_write(4'd4, d[15:8]); cpu_write(4'd5, d[23:16]);
    cpu_write(4'd6, n[7:0]);  cpu_write(4'd7, n[15:8]);
    obs.delete();
  endtask

  task automatic wait_idle(input string name);
    logic [7:0] st;
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 500 && !idle; i++) begin
      cpu_read(4'd8, st);
      if (!st[0]) idle = 1'b1;
    end
    total++;
    if (!idle) begin
      bad++;
      $display("FAIL %s_timeout got=busy want=idle", name);
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({mem_req, mem_wren, mem_addr, dma_int, to_cpu} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%b/%h/%b/%h want=0", mem_req, mem_wren, mem_addr, dma_int, to_cpu);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_read(4'(a), v);
      total++;
      if (v !== 8'h00) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h want=00", a, v);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] st;
    set_regs(24'h000100, 24'h000200, 16'd1);
    model(24'h000100, 24'h000200, 1);
    cpu_write(4'd8, 8'h09);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL single_req_latency got=%b want=1", mem_req);
    end
    cpu_read(4'd8, st);
    total++;
    if (st !== 8'h01) begin
      bad++;
      $display("FAIL single_busy_status got=%h want=01", st);
    end
    wait_idle("single");
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL single_nbursts got=%0d want=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL single_burst%0d got=%h want=%h", i, obs[i], exp_q[i]);
      end
    end
    cpu_read(4'd8, st);
    total++;
    if (st !== 8'h02) begin
      bad++;
      $display("FAIL single_status got=%h want=02", st);
    end
  endtask

  task automatic test_multi;
    logic [23:0] s, d;
    logic [7:0] c0, c1;
    set_regs(24'h000100, 24'h000200, 16'd3);
    model(24'h000100, 24'h000200, 3);
    cpu_write(4'd8, 8'h09);
    wait_idle("multi");
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL multi_nbursts got=%0d want=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL multi_burst%0d got=%h want=%h", i, obs[i], exp_q[i]);
      end
    end
    read24(4'd0, s);
    read24(4'd3, d);
    cpu_read(4'd6, c0);
    cpu_read(4'd7, c1);
    total++;
    if ({s, d, c1, c0} !== {24'h00010C, 24'h00020C, 16'h0000}) begin
      bad++;
      $display("FAIL multi_final got=src %h dst %h cnt %h want=src 00010c dst 00020c cnt 0000", s, d, {c1, c0});
    end
  endtask

  task automatic test_abort;
    logic [23:0] s;
    logic [7:0] st, c0;
    set_regs(24'h001000, 24'h003000, 16'd5);
    model(24'h001000, 24'h003000, 1);
    cpu_write(4'd8, 8'h09);
    cpu_write(4'd8, 8'h02);
    wait_idle("abort");
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL abort_nbursts got=%0d want=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL abort_burst%0d got=%h want=%h", i, obs[i], exp_q[i]);
      end
    end
    cpu_read(4'd8, st);
    cpu_read(4'd6, c0);
    read24(4'd0, s);
    total++;
    if ({st, c0, s} !== {8'h08, 8'h04, 24'h001004}) begin
      bad++;
      $display("FAIL abort_final got=status %h cnt %h src %h want=status 08 cnt 04 src 001004", st, c0, s);
    end
  endtask

  task automatic test_wrap;
    logic [23:0] s;
    set_regs(24'hFFFFFC, 24'h000400, 16'd2);
    model(24'hFFFFFC, 24'h000400, 2);
    cpu_write(4'd8, 8'h09);
    wait_idle("wrap");
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL wrap_nbursts got=%0d want=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL wrap_burst%0d got=%h want=%h", i, obs[i], exp_q[i]);
      end
    end
    read24(4'd0, s);
    total++;
    if (s !== 24'h000004) begin
      bad++;
      $display("FAIL wrap_src got=%h want=000004", s);
    end
  endtask

  task automatic test_int;
    logic [7:0] st;
    set_regs(24'h0, 24'h0, 16'd0);
    cpu_write(4'd8, 8'h0C);
    cpu_write(4'd8, 8'h05);
    total++;
    if (dma_int !== 1'b0) begin
      bad++;
      $display("FAIL int_early got=%b want=0", dma_int);
    end
    @(negedge clk);
    total++;
    if (dma_int !== 1'b1) begin
      bad++;
      $display("FAIL int_rise got=%b want=1", dma_int);
    end
    cpu_read(4'd8, st);
    total++;
    if (st !== 8'h06) begin
      bad++;
      $display("FAIL int_status got=%h want=06", st);
    end
    cpu_write(4'd8, 8'h0C);
    @(negedge clk);
    total++;
    if (dma_int !== 1'b0) begin
      bad++;
      $display("FAIL int_clear got=%b want=0", dma_int);
    end
    cpu_read(4'd8, st);
    total++;
    if (st !== 8'h04) begin
      bad++;
      $display("FAIL int_status_cleared got=%h want=04", st);
    end
    cpu_write(4'd8, 8'h00);
  endtask

  task automatic test_busy_writes;
    logic [23:0] s;
    logic [7:0] c0;
    set_regs(24'h002000, 24'h006000, 16'd2);
    model(24'h002000, 24'h006000, 2);
    cpu_write(4'd8, 8'h09);
    cpu_write(4'd6, 8'h55);
    cpu_write(4'd0, 8'hAA);
    cpu_write(4'd8, 8'h01);
    wait_idle("busy");
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++;
      $display("FAIL busy_nbursts got=%0d want=%0d", obs.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL busy_burst%0d got=%h want=%h", i, obs[i], exp_q[i]);
      end
    end
    read24(4'd0, s);
    cpu_read(4'd6, c0);
    total++;
    if ({s, c0} !== {24'h002008, 8'h00}) begin
      bad++;
      $display("FAIL busy_final got=src %h cnt %h want=src 002008 cnt 00", s, c0);
    end
  endtask

  task automatic test_random;
    logic [23:0] s, d, gs, gd;
    logic [7:0] st;
    int n;
    for (int it = 0; it < 5; it++) begin
      s = 24'($urandom);
      d = 24'($urandom);
      n = $urandom_range(1, 4);
      set_regs(s, d, 16'(n));
      model(s, d, n);
      cpu_write(4'd8, 8'h09);
      wait_idle("rand");
      total++;
      if (obs.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rand%0d_nbursts got=%0d want=%0d", it, obs.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        total++;
        if (obs[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand%0d_burst%0d got=%h want=%h", it, i, obs[i], exp_q[i]);
        end
      end
      read24(4'd0, gs);
      read24(4'd3, gd);
      cpu_read(4'd8, st);
      total++;
      if ({gs, gd, st} !== {s + 24'(4 * n), d + 24'(4 * n), 8'h02}) begin
        bad++;
        $display("FAIL rand%0d_final got=%h %h %h want=%h %h 02", it, gs, gd, st,
                 s + 24'(4 * n), d + 24'(4 * n));
      end
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] v;
    bit seen;
    set_regs(24'h000100, 24'h000200, 16'd2);
    cpu_write(4'd8, 8'h0D);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mem_wren === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rst_mid_no_write got=0 want=1");
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_req, mem_wren, mem_addr} !== 26'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%b/%b/%h want=0", mem_req, mem_wren, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 9; a++) begin
      cpu_read(4'(a), v);
      total++;
      if (v !== 8'h00) begin
        bad++;
        $display("FAIL rst_mid_reg%0d got=%h want=00", a, v);
      end
    end
    total++;
    if (dma_int !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_int got=%b want=0", dma_int);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_abort();
    test_wrap();
    test_int();
    test_busy_writes();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
